// File: rtl/twire_pkg.sv
// rtl/twire_pkg.sv - shared types and constants for the two-wire init sequencer
//
// Holds the table op encoding, the sequencer and transfer state encodings,
// the packed 34-bit table entry layout and the retry gap length.

package twire_pkg;

    typedef enum logic [1:0] {
        OP_WR    = 2'b00,
        OP_DLY   = 2'b01,
        OP_RDCHK = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_XFER,
        ST_RETRY_GAP,
        ST_DELAY,
        ST_DONE,
        ST_FAIL
    } seq_state_e;

    typedef enum logic [1:0] {
        XS_IDLE,
        XS_ISSUE,
        XS_WAIT_ACK,
        XS_WAIT_DONE
    } xfer_state_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] reg_addr;
        logic [15:0] data;
    } entry_t;

    localparam int RETRY_GAP_CYC = 8;

endpackage

// File: rtl/twire_init_seq_if.sv
// rtl/twire_init_seq_if.sv - command/response handshake to the two-wire serial master
//
// master modport: sequencer side (drives rw/valid_in/reg_addr/data_in,
//                 receives busy/valid_out/data_out/error)
// slave modport:  serial master side

interface twire_init_seq_if;
    logic        m_rw;
    logic        m_valid_in;
    logic [15:0] m_reg_addr;
    logic [15:0] m_data_in;
    logic        m_busy;
    logic        m_valid_out;
    logic [15:0] m_data_out;
    logic        m_error;

    modport master (
        output m_rw, m_valid_in, m_reg_addr, m_data_in,
        input  m_busy, m_valid_out, m_data_out, m_error
    );

    modport slave (
        input  m_rw, m_valid_in, m_reg_addr, m_data_in,
        output m_busy, m_valid_out, m_data_out, m_error
    );
endinterface

// File: rtl/twire_init_seq_xfer_ctl.sv
// rtl/twire_init_seq_xfer_ctl.sv - one master transaction: issue, ack wait, busy wait, timeouts
//
// Ports:
//   clk, sync_rst_n        clock, synchronous active-low reset
//   start_i                begin a transaction with rw_i/reg_addr_i/data_i
//   mif                    master handshake (master modport)
//   done_o                 one-cycle pulse when the attempt ends
//   ok_o                   valid with done_o: handshake finished without error/timeout
//   rd_vld_o, rd_data_o    read strobe seen during the attempt and its latched data

module twire_xfer_ctl
    import twire_pkg::*;
#(
    parameter int ACK_TO  = 16,
    parameter int XFER_TO = 65535
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic                  start_i,
    input  logic                  rw_i,
    input  logic [15:0]           reg_addr_i,
    input  logic [15:0]           data_i,
    twire_init_seq_if.master      mif,
    output logic                  done_o,
    output logic                  ok_o,
    output logic                  rd_vld_o,
    output logic [15:0]           rd_data_o
);

    xfer_state_e xs_q, xs_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        rd_vld_q, rd_vld_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        vout_prev_q;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            xs_q        <= XS_IDLE;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
            vout_prev_q <= 1'b0;
        end else begin
            xs_q        <= xs_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            rd_vld_q    <= rd_vld_d;
            rd_data_q   <= rd_data_d;
            vout_prev_q <= mif.m_valid_out;
        end
    end

    always_comb begin
        xs_d      = xs_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        done_d    = 1'b0;
        ok_d      = ok_q;
        rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q;

        case (xs_q)
            XS_IDLE: begin
                if (start_i) begin
                    xs_d      = XS_ISSUE;
                    rw_d      = rw_i;
                    addr_d    = reg_addr_i;
                    wdata_d   = data_i;
                    err_d     = 1'b0;
                    ok_d      = 1'b0;
                    rd_vld_d  = 1'b0;
                    rd_data_d = '0;
                    cnt_d     = '0;
                end
            end
            XS_ISSUE: begin
                err_d = err_q | mif.m_error;
                cnt_d = '0;
                xs_d  = XS_WAIT_ACK;
            end
            XS_WAIT_ACK: begin
                err_d = err_q | mif.m_error;
                if (mif.m_busy) begin
                    cnt_d = '0;
                    xs_d  = XS_WAIT_DONE;
                end else if (cnt_q >= 32'(ACK_TO - 1)) begin
                    // Busy never came, so there is nothing to wait out.
                    xs_d   = XS_IDLE;
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            XS_WAIT_DONE: begin
                err_d = err_q | mif.m_error;
                if (!mif.m_busy) begin
                    xs_d   = XS_IDLE;
                    done_d = 1'b1;
                    ok_d   = !(err_q | mif.m_error);
                end else if (cnt_q >= 32'(XFER_TO - 1)) begin
                    xs_d   = XS_IDLE;
                    done_d = 1'b1;
                    ok_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: xs_d = XS_IDLE;
        endcase

        // Read data is latched on the strobe's rising edge, only inside a read attempt.
        if (xs_q != XS_IDLE && rw_q && mif.m_valid_out && !vout_prev_q) begin
            rd_vld_d  = 1'b1;
            rd_data_d = mif.m_data_out;
        end
    end

    assign mif.m_valid_in = (xs_q == XS_ISSUE);
    assign mif.m_rw       = rw_q;
    assign mif.m_reg_addr = addr_q;
    assign mif.m_data_in  = wdata_q;
    assign done_o         = done_q;
    assign ok_o           = ok_q;
    assign rd_vld_o       = rd_vld_q;
    assign rd_data_o      = rd_data_q;

endmodule

// File: rtl/twire_init_seq.sv
// rtl/twire_init_seq.sv - table-driven bring-up sequencer for the two-wire serial master
//
// Walks the configuration table from index 0 after start, issuing writes,
// read-checks and delays, retrying failed transfers up to MAX_RETRY times.
// Optional feature macro: TWIRE_INIT_READCHECK_EN (undefined: op READ_CHECK
// is skipped without a transaction).
//
// Ports:
//   clk, sync_rst_n   clock, synchronous active-low reset
//   start             one-cycle start, honoured in IDLE/DONE/FAIL
//   tbl_addr/tbl_data table index out, entry in one cycle later
//   mif               master handshake (master modport)
//   seq_busy          sequencer active
//   done, fail        completion levels; fail_idx = entry that exhausted retries

module twire_init_seq
    import twire_pkg::*;
#(
    parameter int TBL_AW    = 6,
    parameter int MAX_RETRY = 3,
    parameter int DLY_UNIT  = 1000,
    parameter int ACK_TO    = 16,
    parameter int XFER_TO   = 65535
) (
    input  logic              clk,
    input  logic              sync_rst_n,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [33:0]       tbl_data,
    twire_init_seq_if.master  mif,
    output logic              seq_busy,
    output logic              done,
    output logic              fail,
    output logic [TBL_AW-1:0] fail_idx
);

    seq_state_e        state_q, state_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [7:0]        retry_q, retry_d;
    logic [3:0]        gap_q, gap_d;
    logic [31:0]       dly_q, dly_d;
    entry_t            entry_q, entry_d;
    logic [TBL_AW-1:0] fail_idx_q, fail_idx_d;

    entry_t      tbl_ent;
    logic        advance;
    logic        xfer_start;
    logic        xfer_done;
    logic        xfer_ok;
    logic        xfer_pass;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic [31:0] dly_load;

    assign tbl_ent  = entry_t'(tbl_data);
    assign dly_load = 32'(tbl_ent.data) * 32'(DLY_UNIT);

    // A read-check only passes if the strobe arrived and carried the expected data.
    assign xfer_pass = xfer_ok &&
                       ((entry_q.op != OP_RDCHK) || (rd_vld && rd_data == entry_q.data));

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            gap_q      <= '0;
            dly_q      <= '0;
            entry_q    <= '0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            gap_q      <= gap_d;
            dly_q      <= dly_d;
            entry_q    <= entry_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        gap_d      = gap_q;
        dly_d      = dly_q;
        entry_d    = entry_q;
        fail_idx_d = fail_idx_q;
        advance    = 1'b0;
        xfer_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    idx_d      = '0;
                    retry_d    = '0;
                    fail_idx_d = '0;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                entry_d = tbl_ent;
                case (tbl_ent.op)
                    OP_WR: begin
                        xfer_start = 1'b1;
                        state_d    = ST_XFER;
                    end
                    OP_RDCHK: begin
`ifdef TWIRE_INIT_READCHECK_EN
                        xfer_start = 1'b1;
                        state_d    = ST_XFER;
`else
                        advance = 1'b1;
`endif
                    end
                    OP_DLY: begin
                        dly_d = dly_load;
                        if (dly_load == 32'd0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = ST_DELAY;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_XFER: begin
                if (xfer_done) begin
                    if (xfer_pass) begin
                        advance = 1'b1;
                    end else if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        gap_d   = 4'(RETRY_GAP_CYC - 1);
                        state_d = ST_RETRY_GAP;
                    end else begin
                        fail_idx_d = idx_q;
                        state_d    = ST_FAIL;
                    end
                end
            end
            ST_RETRY_GAP: begin
                if (gap_q == 4'd0) begin
                    xfer_start = 1'b1;
                    state_d    = ST_XFER;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            ST_DELAY: begin
                if (dly_q <= 32'd1) begin
                    advance = 1'b1;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The last table slot finishing is an implicit END; the index never wraps.
        if (advance) begin
            retry_d = '0;
            if (idx_q == '1) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + TBL_AW'(1);
                state_d = ST_FETCH;
            end
        end
    end

    // entry_d carries the freshly decoded entry in DECODE and the held one on retries.
    twire_xfer_ctl #(
        .ACK_TO  (ACK_TO),
        .XFER_TO (XFER_TO)
    ) u_xfer (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .start_i    (xfer_start),
        .rw_i       (entry_d.op == OP_RDCHK),
        .reg_addr_i (entry_d.reg_addr),
        .data_i     (entry_d.data),
        .mif        (mif),
        .done_o     (xfer_done),
        .ok_o       (xfer_ok),
        .rd_vld_o   (rd_vld),
        .rd_data_o  (rd_data)
    );

    assign tbl_addr = idx_q;
    assign seq_busy = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
    assign done     = (state_q == ST_DONE);
    assign fail     = (state_q == ST_FAIL);
    assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_twire_init_seq.sv
// tb/tb_twire_init_seq.sv - self-checking bench for twire_init_seq

module tb_twire_init_seq;
    import twire_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          sync_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [33:0]   tbl_data;
    logic          seq_busy, done, fail;
    logic [AW-1:0] fail_idx;

    twire_init_seq_if mif();

    twire_init_seq #(
        .TBL_AW(AW), .MAX_RETRY(3), .DLY_UNIT(10), .ACK_TO(16), .XFER_TO(200)
    ) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .mif(mif),
        .seq_busy(seq_busy), .done(done), .fail(fail), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [33:0] tbl [DEPTH];

    // master model controls
    int          err_left = 0;
    logic [15:0] err_addr = 16'h0;
    bit          no_busy = 1'b0;
    bit          long_busy = 1'b0;
    bit          rd_ovr_en = 1'b0;
    logic [15:0] rd_ovr = 16'h0;

    typedef struct {
        int          cyc;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] data;
        int          last_fall;
    } pulse_t;
    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    pulse_t pulses[$];
    txn_t   exp_q[$];
    int     cyc = 0;
    int     last_fall = 0;
    int     done_cyc = -1;
    int     addr_cyc [DEPTH];

    // table memory: data follows the address with a one-cycle lag
    initial begin
        tbl_data = '0;
        forever begin
            @(negedge clk);
            tbl_data = tbl[tbl_addr];
        end
    end

    // serial master model
    initial begin
        logic        rw_s;
        logic [15:0] a_s;
        int          len;
        mif.m_busy = 1'b0; mif.m_valid_out = 1'b0; mif.m_data_out = 16'h0; mif.m_error = 1'b0;
        forever begin
            @(negedge clk);
            if (mif.m_valid_in === 1'b1 && !no_busy) begin
                rw_s = mif.m_rw;
                a_s  = mif.m_reg_addr;
                len  = long_busy ? 20 : int'($urandom_range(2, 5));
                @(negedge clk);
                mif.m_busy = 1'b1;
                if (err_left > 0 && a_s == err_addr) begin
                    mif.m_error = 1'b1;
                    err_left--;
                end
                for (int k = 0; k < len; k++) begin
                    @(negedge clk);
                    mif.m_error     = 1'b0;
                    mif.m_valid_out = rw_s && (k == 1);
                    mif.m_data_out  = rd_ovr_en ? rd_ovr : (a_s ^ 16'h5A5A);
                end
                @(negedge clk);
                mif.m_busy = 1'b0; mif.m_valid_out = 1'b0; mif.m_error = 1'b0;
            end
        end
    end

    // monitor: samples just after each rising edge
    initial begin
        logic          busy_prev = 1'b0;
        logic          done_prev = 1'b0;
        logic [AW-1:0] addr_prev = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy_prev && !mif.m_busy) last_fall = cyc;
            busy_prev = mif.m_busy;
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;
            if (tbl_addr !== addr_prev) addr_cyc[tbl_addr] = cyc;
            addr_prev = tbl_addr;
            if (mif.m_valid_in === 1'b1)
                pulses.push_back('{cyc, mif.m_rw, mif.m_reg_addr, mif.m_data_in, last_fall});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] ent(logic [1:0] op, logic [15:0] a, logic [15:0] d);
        return {op, a, d};
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < DEPTH; i++) tbl[i] = ent(OP_END, 16'h0, 16'h0);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 100 && mif.m_busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic run(string tag);
        bit timed_out;
        wait_quiet();
        pulses.delete();
        done_cyc = -1;
        for (int i = 0; i < DEPTH; i++) addr_cyc[i] = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done || fail) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, timed_out, 0);
    endtask

    // Expected transactions derived by walking the table from the op rules.
    task automatic build_expected();
        logic [1:0] op;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            op = tbl[i][33:32];
            if (op == OP_END) break;
            if (op == OP_WR) exp_q.push_back('{1'b0, tbl[i][31:16], tbl[i][15:0]});
`ifdef TWIRE_INIT_READCHECK_EN
            if (op == OP_RDCHK) exp_q.push_back('{1'b1, tbl[i][31:16], tbl[i][15:0]});
`endif
        end
    endtask

    task automatic compare_txns(string tag);
        int n;
        check({tag, "_count"}, pulses.size(), exp_q.size());
        n = (pulses.size() < exp_q.size()) ? pulses.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_rw"},   pulses[i].rw,   exp_q[i].rw);
            check({tag, "_addr"}, pulses[i].addr, exp_q[i].addr);
            check({tag, "_data"}, pulses[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        int gap;
        int dd;
        bit seen;
        clear_tbl();

        // reset state
        repeat (3) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_valid_in", mif.m_valid_in, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_cmd", {mif.m_rw, mif.m_reg_addr, mif.m_data_in}, 0);
        sync_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two writes then END
        clear_tbl();
        tbl[0] = ent(OP_WR, 16'h3012, 16'h0100);
        tbl[1] = ent(OP_WR, 16'h301A, 16'h10DC);
        build_expected();
        run("two_wr");
        compare_txns("two_wr");
        check("two_wr_done", done, 1);
        check("two_wr_fail", fail, 0);
        check("two_wr_done_after_busy", done_cyc > last_fall, 1);

        // write, delay 3 ticks, write
        clear_tbl();
        tbl[0] = ent(OP_WR, 16'h3020, 16'h0001);
        tbl[1] = ent(OP_DLY, 16'h0000, 16'd3);
        tbl[2] = ent(OP_WR, 16'h3022, 16'h0002);
        build_expected();
        run("dly");
        compare_txns("dly");
        check("dly_done", done, 1);
        if (pulses.size() >= 2) begin
            dd = pulses[1].cyc - (addr_cyc[1] + 1);
            check("dly_spacing", (dd >= 30 && dd <= 40), 1);
        end

        // error on entry 1 for its first two attempts
        clear_tbl();
        tbl[0] = ent(OP_WR, 16'h3010, 16'h0001);
        tbl[1] = ent(OP_WR, 16'h3100, 16'h00AA);
        err_addr = 16'h3100;
        err_left = 2;
        run("err");
        check("err_pulses", pulses.size(), 4);
        for (int k = 1; k < 4 && k < pulses.size(); k++) check("err_addr", pulses[k].addr, 16'h3100);
        for (int k = 2; k < 4 && k < pulses.size(); k++) begin
            gap = pulses[k].cyc - pulses[k].last_fall;
            check("err_gap", (gap >= 8 && gap <= 12), 1);
        end
        check("err_done", done, 1);
        check("err_fail", fail, 0);
        err_left = 0;

        // master never acknowledges
        clear_tbl();
        tbl[0] = ent(OP_WR, 16'h3030, 16'h5555);
        no_busy = 1'b1;
        run("noack");
        check("noack_pulses", pulses.size(), 4);
        check("noack_fail", fail, 1);
        check("noack_fail_idx", fail_idx, 0);
        check("noack_seq_busy", seq_busy, 0);
        check("noack_done", done, 0);
        no_busy = 1'b0;

        // read-check with wrong data from the master
        clear_tbl();
        tbl[0] = ent(OP_RDCHK, 16'h3000, 16'h2604);
        rd_ovr_en = 1'b1;
        rd_ovr = 16'h2605;
        run("rdchk");
`ifdef TWIRE_INIT_READCHECK_EN
        check("rdchk_pulses", pulses.size(), 4);
        if (pulses.size() > 0) check("rdchk_rw", pulses[0].rw, 1);
        check("rdchk_fail", fail, 1);
        check("rdchk_fail_idx", fail_idx, 0);
`else
        check("rdchk_pulses", pulses.size(), 0);
        check("rdchk_done", done, 1);
        check("rdchk_fail", fail, 0);
`endif
        rd_ovr_en = 1'b0;

        // reset during WAIT_DONE of entry 1, then restart
        clear_tbl();
        tbl[0] = ent(OP_WR, 16'h3040, 16'h1111);
        tbl[1] = ent(OP_WR, 16'h3050, 16'h2222);
        wait_quiet();
        pulses.delete();
        long_busy = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pulses.size() >= 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_reach_entry1", seen, 1);
        repeat (5) @(negedge clk);
        sync_rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_valid_in", mif.m_valid_in, 0);
        check("rstmid_levels", {seq_busy, done, fail}, 0);
        check("rstmid_tbl_addr", tbl_addr, 0);
        check("rstmid_fail_idx", fail_idx, 0);
        check("rstmid_cmd", {mif.m_rw, mif.m_reg_addr, mif.m_data_in}, 0);
        wait_quiet();
        long_busy = 1'b0;
        sync_rst_n = 1'b1;
        @(negedge clk);
        build_expected();
        run("restart");
        compare_txns("restart");
        check("restart_done", done, 1);

        // randomized tables; the last one has no END and must stop at the final slot
        for (int it = 0; it < 3; it++) begin
            int n;
            int op;
            logic [15:0] a;
            clear_tbl();
            n = (it == 2) ? DEPTH : int'($urandom_range(3, 8));
            for (int i = 0; i < n; i++) begin
                op = int'($urandom_range(0, 2));
                a  = 16'($urandom);
                if (op == 0) tbl[i] = ent(OP_WR, a, 16'($urandom));
                else if (op == 1) tbl[i] = ent(OP_DLY, 16'h0, 16'($urandom_range(0, 2)));
                else tbl[i] = ent(OP_RDCHK, a, a ^ 16'h5A5A);
            end
            build_expected();
            run("rand");
            compare_txns("rand");
            check("rand_done", done, 1);
            check("rand_fail", fail, 0);
            if (it == 2) check("rand_last_idx", tbl_addr, DEPTH - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twire_init_seq.md
Name: twire_init_seq

Overview:
- Upstream command sequencer for the two-wire serial master.
- Walks an external configuration table of (op, reg_addr, data) entries after a start pulse.
- Issues each write or read-check to the master through its rw/valid_in/reg_addr/data_in handshake, and inserts programmable delays.
- Retries failed transactions and reports done or fail with the failing entry index; this is the sensor bring-up path.

Parameters:
- TBL_AW, 6, table index width; table depth is 2**TBL_AW entries.
- MAX_RETRY, 3, retries per entry after the first attempt fails.
- DLY_UNIT, 1000, clk cycles per delay tick.
- ACK_TO, 16, cycles allowed after the valid_in pulse for the master to raise busy.
- XFER_TO, 65535, maximum cycles busy may stay high.

Ports:
- clk  in  1  system clock
- sync_rst_n  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; accepted only in IDLE, DONE or FAIL
- tbl_addr  out  TBL_AW  table index
- tbl_data  in  34  {op[33:32], reg_addr[31:16], data[15:0]}; valid one cycle after tbl_addr
- m_rw  out  1  to master: 1 = read, 0 = write
- m_valid_in  out  1  to master: one-cycle start pulse
- m_reg_addr  out  16  to master: register address
- m_data_in  out  16  to master: write data
- m_busy  in  1  from master busy
- m_valid_out  in  1  from master read-data strobe
- m_data_out  in  16  from master read data
- m_error  in  1  from master error
- seq_busy  out  1  high in every state except IDLE/DONE/FAIL
- done  out  1  level; table completed
- fail  out  1  level; entry exhausted its retries
- fail_idx  out  TBL_AW  index of the failing entry

Behaviour:
- Reset values: every output 0, state IDLE, index 0, retry counter 0.
- sync_rst_n low mid-transaction aborts immediately; m_valid_in is 0 on the next edge.
- Ops: 00 WRITE, 01 DELAY (data = tick count; 0 means no wait), 10 READ_CHECK, 11 END.
- State flow:
  - IDLE/DONE/FAIL --start--> FETCH.
  - Start clears done, fail, fail_idx and index.
  - FETCH drives tbl_addr and moves to DECODE after 1 cycle.
  - DECODE captures tbl_data and dispatches on op.
- WRITE/READ_CHECK:
  - ISSUE holds m_rw/m_reg_addr/m_data_in stable from ISSUE until WAIT_DONE exits.
  - ISSUE pulses m_valid_in for exactly one cycle, then goes to WAIT_ACK.
  - WAIT_ACK: m_busy must rise within ACK_TO cycles, else the attempt fails.
  - WAIT_DONE: waits for m_busy to fall; m_busy high more than XFER_TO cycles fails the attempt.
  - Any m_error sampled from ISSUE through WAIT_DONE fails the attempt; the sequencer still waits for m_busy low before retrying.
- READ_CHECK: latch m_data_out on the m_valid_out rising edge. After busy falls, a missing strobe or a data mismatch fails the attempt.
- Failed attempt: RETRY_GAP of 8 cycles, then ISSUE again while retries used < MAX_RETRY. Otherwise go to FAIL with fail=1 and fail_idx = index.
- Successful entry: retry counter cleared, index+1, FETCH.
- DELAY: counts data × DLY_UNIT cycles with a 32-bit counter, then advances.
- END: DONE with done=1.
- Index == 2**TBL_AW-1 completing successfully: DONE (implicit end, no wrap).
- start while seq_busy: ignored.
- m_valid_out outside READ_CHECK: ignored.

Optional Feature:
- TWIRE_INIT_READCHECK_EN defined: READ_CHECK is executed as described.
- Undefined: op 10 is a no-op that advances index after DECODE. No master transaction is issued; m_data_out and m_valid_out are unused.

Decomposition:
- twire_pkg holds:
  - op enum (OP_WR, OP_DLY, OP_RDCHK, OP_END);
  - state enum;
  - entry struct {op, reg_addr, data} packed to 34 bits;
  - RETRY_GAP_CYC = 8.
- One natural sub-module, twire_xfer_ctl: ISSUE/WAIT_ACK/WAIT_DONE handshake plus timeouts. It returns a pass/fail pulse and the latched read data. The table walker and retry logic stay in the top module.

Test Plan:
- Table {WR 0x3012←0x0100, WR 0x301A←0x10DC, END}, master model accepts:
  - two m_valid_in pulses, each with correct addr/data/rw=0;
  - done=1 after the second busy falls;
  - fail=0.
- DELAY entry data=3, DLY_UNIT=10 between two writes: second m_valid_in occurs no earlier than 30 cycles after the DELAY is decoded.
- Model asserts m_error on entry 1 for the first 2 attempts:
  - 3 pulses on entry 1, 8-cycle gaps between attempts;
  - then success and done=1.
- Model never raises busy, MAX_RETRY=3: 4 attempts, then fail=1, fail_idx=0, seq_busy=0.
- READ_CHECK 0x3000 expect 0x2604, model returns 0x2605: 4 attempts, then fail=1. With the macro undefined: no transaction issued and done=1.
- Reset pulled low during WAIT_DONE:
  - all outputs 0 next edge;
  - a new start restarts at index 0.
